// File: rtl/product_accumulator.sv
// Signed product accumulator: sums N_TERMS multiplier products per frame and hands the
// narrowed sum downstream over valid/ready. Define PRODUCT_ACC_SAT_EN for saturating narrowing.
module product_accumulator #(
  parameter int unsigned IN_W    = 26,
  parameter int unsigned N_TERMS = 784,
  parameter int unsigned ACC_W   = 36,
  parameter int unsigned OUT_W   = 32
) (
  input  logic                         clk,
  input  logic                         GlobalReset,
  input  logic [IN_W-1:0]              ProductPort,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic                         Clear,
  output logic [OUT_W-1:0]             Result,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [$clog2(N_TERMS)-1:0]   TermCount
`ifdef PRODUCT_ACC_SAT_EN
  ,
  output logic                         SatFlag
`endif
);

  localparam int unsigned CntW = $clog2(N_TERMS);

  typedef enum logic [0:0] {StAccum, StDone} state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]  result_q, result_d;
  logic [ACC_W-1:0]  prod_ext, sum_full;
  logic [OUT_W-1:0]  narrowed;
  logic              last;

  assign prod_ext = {{(ACC_W-IN_W){ProductPort[IN_W-1]}}, ProductPort};
  assign sum_full = acc_q + prod_ext;
  assign last     = (cnt_q == CntW'(N_TERMS - 1));

`ifdef PRODUCT_ACC_SAT_EN
  logic                 sat_q, sat_d, clamp;
  logic [ACC_W-OUT_W:0] hi_bits;

  // The sum fits in OUT_W bits only if every bit from the OUT_W sign bit upward agrees.
  assign hi_bits = sum_full[ACC_W-1:OUT_W-1];
  assign clamp   = !((&hi_bits) || !(|hi_bits));

  always_comb begin
    narrowed = OUT_W'(sum_full);
    if (clamp) begin
      narrowed = sum_full[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign narrowed = OUT_W'(sum_full);
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef PRODUCT_ACC_SAT_EN
    sat_d    = sat_q;
`endif
    unique case (state_q)
      StAccum: begin
        if (Clear) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (InValid) begin
          if (last) begin
            result_d = narrowed;
`ifdef PRODUCT_ACC_SAT_EN
            sat_d    = clamp;
`endif
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StDone;
          end else begin
            acc_d = sum_full;
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        // Clear leaves Result untouched; it only abandons the pending handshake.
        if (Clear || OutReady) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q  <= StAccum;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef PRODUCT_ACC_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef PRODUCT_ACC_SAT_EN
      sat_q    <= sat_d;
`endif
    end
  end

  assign InReady   = (state_q == StAccum);
  assign OutValid  = (state_q == StDone);
  assign Result    = result_q;
  assign TermCount = cnt_q;
`ifdef PRODUCT_ACC_SAT_EN
  assign SatFlag   = sat_q;
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 32-bit-result and a 16-bit-result instance share stimulus
// and are checked every cycle against a frame-level model plus literal expectations.
module tb_product_accumulator;

  localparam int unsigned NT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [25:0] product;
  logic        in_valid;
  logic        clear;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] result_a;
  logic [15:0] result_b;
  logic [1:0]  term_cnt_a, term_cnt_b;
`ifdef PRODUCT_ACC_SAT_EN
  logic        sat_a, sat_b;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  product_accumulator #(.IN_W(26), .N_TERMS(NT), .ACC_W(36), .OUT_W(32)) u_dut_a (
    .clk         (clk),
    .GlobalReset (rst_n),
    .ProductPort (product),
    .InValid     (in_valid),
    .InReady     (in_ready_a),
    .Clear       (clear),
    .Result      (result_a),
    .OutValid    (out_valid_a),
    .OutReady    (out_ready),
    .TermCount   (term_cnt_a)
`ifdef PRODUCT_ACC_SAT_EN
    ,
    .SatFlag     (sat_a)
`endif
  );

  product_accumulator #(.IN_W(26), .N_TERMS(NT), .ACC_W(36), .OUT_W(16)) u_dut_b (
    .clk         (clk),
    .GlobalReset (rst_n),
    .ProductPort (product),
    .InValid     (in_valid),
    .InReady     (in_ready_b),
    .Clear       (clear),
    .Result      (result_b),
    .OutValid    (out_valid_b),
    .OutReady    (out_ready),
    .TermCount   (term_cnt_b)
`ifdef PRODUCT_ACC_SAT_EN
    ,
    .SatFlag     (sat_b)
`endif
  );

  // Frame-level model: products of the current frame are stored, the frame total is a plain sum.
  bit     m_done = 1'b0;
  int     m_cnt  = 0;
  longint m_total = 0;
  longint m_terms [NT];

  function automatic longint frame_sum(input longint last_prod);
    longint s = last_prod;
    for (int i = 0; i < int'(NT) - 1; i++) s += m_terms[i];
    return s;
  endfunction

  function automatic longint narrow(input longint v, input int w);
    longint maxv = (longint'(1) << (w - 1)) - 1;
    longint minv = -maxv - 1;
    longint m    = longint'(1) << w;
    longint r;
`ifdef PRODUCT_ACC_SAT_EN
    if (v > maxv) return maxv;
    if (v < minv) return minv;
    r = v;
`else
    r = ((v % m) + m) % m;
    if (r > maxv) r -= m;
`endif
    return r;
  endfunction

  function automatic longint clamped(input longint v, input int w);
    longint maxv = (longint'(1) << (w - 1)) - 1;
    return ((v > maxv) || (v < -maxv - 1)) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done  <= 1'b0;
      m_cnt   <= 0;
      m_total <= 0;
    end else if (!m_done) begin
      if (clear) begin
        m_cnt <= 0;
      end else if (in_valid) begin
        if (m_cnt == int'(NT) - 1) begin
          m_total <= frame_sum(longint'($signed(product)));
          m_cnt   <= 0;
          m_done  <= 1'b1;
        end else begin
          m_terms[m_cnt] <= longint'($signed(product));
          m_cnt          <= m_cnt + 1;
        end
      end
    end else if (clear || out_ready) begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model in_ready_a",  longint'(in_ready_a),  longint'(!m_done));
      chk("model out_valid_a", longint'(out_valid_a), longint'(m_done));
      chk("model term_cnt_a",  longint'(term_cnt_a),  longint'(m_cnt));
      chk("model result_a",    longint'($signed(result_a)), narrow(m_total, 32));
      chk("model in_ready_b",  longint'(in_ready_b),  longint'(!m_done));
      chk("model out_valid_b", longint'(out_valid_b), longint'(m_done));
      chk("model term_cnt_b",  longint'(term_cnt_b),  longint'(m_cnt));
      chk("model result_b",    longint'($signed(result_b)), narrow(m_total, 16));
`ifdef PRODUCT_ACC_SAT_EN
      chk("model sat_a", longint'(sat_a), clamped(m_total, 32));
      chk("model sat_b", longint'(sat_b), clamped(m_total, 16));
`endif
    end
  end

  task automatic cyc(input bit v, input longint p, input bit clr, input bit rdy);
    logic [63:0] pv;
    pv        = p;
    in_valid  = v;
    product   = pv[25:0];
    clear     = clr;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input longint p0, input longint p1, input longint p2, input longint p3,
                       input bit rdy);
    cyc(1'b1, p0, 1'b0, rdy);
    cyc(1'b1, p1, 1'b0, rdy);
    cyc(1'b1, p2, 1'b0, rdy);
    cyc(1'b1, p3, 1'b0, rdy);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    product   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("reset in_ready",  longint'(in_ready_a), 1);
    chk("reset out_valid", longint'(out_valid_a), 0);
    chk("reset term_cnt",  longint'(term_cnt_a), 0);
    chk("reset result",    longint'($signed(result_a)), 0);
    rst_n = 1'b1;

    // Basic sum
    frame(0, 50, 400, 2000, 1'b1);
    chk("basic out_valid", longint'(out_valid_a), 1);
    chk("basic in_ready",  longint'(in_ready_a), 0);
    chk("basic result",    longint'($signed(result_a)), 2450);
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("basic valid drop",   longint'(out_valid_a), 0);
    chk("basic ready return", longint'(in_ready_a), 1);

    // Signed mix, then an all -1 frame proves the accumulator restarted from zero
    frame(-100, 30, -5, 1000, 1'b1);
    chk("signed result", longint'($signed(result_a)), 925);
    cyc(1'b0, 0, 1'b0, 1'b1);
    frame(-1, -1, -1, -1, 1'b1);
    chk("minus ones result_a", longint'($signed(result_a)), -4);
    chk("minus ones result_b", longint'($signed(result_b)), -4);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Backpressure with products still offered during DONE
    frame(0, 50, 400, 2000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 7, 1'b0, 1'b0);
      chk("bp result",   longint'($signed(result_a)), 2450);
      chk("bp in_ready", longint'(in_ready_a), 0);
      chk("bp term_cnt", longint'(term_cnt_a), 0);
    end
    cyc(1'b1, 7, 1'b0, 1'b1);
    chk("bp handshake term_cnt", longint'(term_cnt_a), 0);
    cyc(1'b1, 7, 1'b0, 1'b1);
    chk("bp restart term_cnt", longint'(term_cnt_a), 1);
    cyc(1'b1, 7, 1'b0, 1'b1);
    cyc(1'b1, 7, 1'b0, 1'b1);
    cyc(1'b1, 7, 1'b0, 1'b1);
    chk("bp next result", longint'($signed(result_a)), 28);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Input bubbles and Clear
    cyc(1'b1, 10, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    cyc(1'b1, 20, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("bubble term_cnt", longint'(term_cnt_a), 2);
    cyc(1'b1, 99, 1'b1, 1'b1);
    chk("clear term_cnt", longint'(term_cnt_a), 0);
    frame(1, 2, 3, 4, 1'b1);
    chk("clear result", longint'($signed(result_a)), 10);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Clear while DONE drops OutValid but keeps Result
    frame(5, 5, 5, 5, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("done clear valid",  longint'(out_valid_a), 0);
    chk("done clear result", longint'($signed(result_a)), 20);

    // Asynchronous reset mid-frame
    frame(500, 500, 500, 0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    frame(500, 500, 500, 0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    cyc(1'b1, 500, 1'b0, 1'b1);
    cyc(1'b1, 500, 1'b0, 1'b1);
    cyc(1'b1, 500, 1'b0, 1'b1);
    chk("pre-reset term_cnt", longint'(term_cnt_a), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset term_cnt", longint'(term_cnt_a), 0);
    chk("async reset result",   longint'($signed(result_a)), 0);
    chk("async reset in_ready", longint'(in_ready_a), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame(1, 1, 1, 1, 1'b1);
    chk("post-reset result", longint'($signed(result_a)), 4);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Narrowing to 16 bits
    frame(20000, 20000, 20000, 20000, 1'b1);
    chk("wide 80000", longint'($signed(result_a)), 80000);
`ifdef PRODUCT_ACC_SAT_EN
    chk("narrow sat max", longint'($signed(result_b)), 32767);
    chk("narrow sat flag", longint'(sat_b), 1);
`else
    chk("narrow wrap pos", longint'($signed(result_b)), 14464);
`endif
    cyc(1'b0, 0, 1'b0, 1'b1);
    frame(-20000, -20000, -20000, -20000, 1'b1);
    chk("wide -80000", longint'($signed(result_a)), -80000);
`ifdef PRODUCT_ACC_SAT_EN
    chk("narrow sat min", longint'($signed(result_b)), -32768);
`else
    chk("narrow wrap neg", longint'($signed(result_b)), -14464);
`endif
    cyc(1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
